// File: rtl/debug_dispatch_pkg.sv
// Shared types and width helpers for the JTAG debug command dispatcher.
package debug_dispatch_pkg;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_DISPATCH = 1'b1
  } dispatch_state_e;

  // Core-select width: room for every core index plus the broadcast code.
  function automatic int sel_width(input int num_cores);
    int w;
    w = $clog2(num_cores + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int tmo_width(input int timeout_cyc);
    int w;
    w = $clog2(timeout_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/toggle_sync_edge.sv
// Brings a TCK-domain toggle into clk and flags each level change as a one-cycle event.
module toggle_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tgl,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   ref_r;

  // Synchronizer chain, intentionally left without reset.
  always_ff @(posedge clk) begin
    sync_r <= {sync_r[SYNC_STAGES-2:0], tgl};
  end

  // Edge reference follows the synced level, also during reset, so release is event-free.
  always_ff @(posedge clk) begin
    ref_r <= sync_r[SYNC_STAGES-1];
  end

  assign evt = ~reset & (sync_r[SYNC_STAGES-1] ^ ref_r);

endmodule

// File: rtl/debug_cmd_dispatch.sv
// Captures JTAG update-DR commands and hands them to one or all debug cores,
// with timeout, overrun and bad-select reporting.
module debug_cmd_dispatch
  import debug_dispatch_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1023,
  parameter bit BCAST_EN    = 1'b1,
  localparam int SELW       = sel_width(NUM_CORES),
  localparam int TMOW       = tmo_width(TIMEOUT_CYC)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 jtag_udr_tgl,
  input  logic                 jtag_uir_tgl,
  input  logic [IR_W-1:0]      jtag_ir,
  input  logic [DATA_W-1:0]    jtag_sr,
  input  logic [SELW-1:0]      jtag_sel,
  input  logic [NUM_CORES-1:0] cmd_ready,
  input  logic                 err_clr,
  output logic [DATA_W-1:0]    jdo,
  output logic [IR_W-1:0]      ir_q,
  output logic [NUM_CORES-1:0] cmd_valid,
  output logic                 busy,
  output logic                 err_overrun,
  output logic                 err_timeout,
  output logic                 err_sel,
  output logic [15:0]          cmd_count
);

  dispatch_state_e        state_r, state_nxt;
  logic                   udr_evt_s, uir_evt_s;
  logic [DATA_W-1:0]      jdo_r;
  logic [IR_W-1:0]        ir_q_r;
  logic [SELW-1:0]        sel_r;
  logic [NUM_CORES-1:0]   cmd_valid_r, cmd_valid_nxt;
  logic [NUM_CORES-1:0]   tgt_s, pending_s;
  logic                   sel_ok_s, load_r, busy_r;
  logic [TMOW-1:0]        tmo_r, tmo_inc_s;
  logic                   tmo_hit_s, done_s, sel_bad_s, accept_s;
  logic                   complete_s, tmo_fire_s, sel_fire_s, overrun_fire_s;
  logic                   err_overrun_r, err_timeout_r, err_sel_r;
  logic [15:0]            cmd_count_r;

  toggle_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk(clk), .reset(reset), .tgl(jtag_udr_tgl), .evt(udr_evt_s)
  );

  toggle_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk(clk), .reset(reset), .tgl(jtag_uir_tgl), .evt(uir_evt_s)
  );

  // Select decode: one-hot core, broadcast code, or invalid.
  always_comb begin
    tgt_s    = '0;
    sel_ok_s = 1'b0;
    if (sel_r < SELW'(NUM_CORES)) begin
      tgt_s    = NUM_CORES'(1'b1) << sel_r;
      sel_ok_s = 1'b1;
    end else if (BCAST_EN && (sel_r == SELW'(NUM_CORES))) begin
      tgt_s    = '1;
      sel_ok_s = 1'b1;
    end else begin
      tgt_s    = '0;
      sel_ok_s = 1'b0;
    end
  end

  // load_r marks the first DISPATCH cycle, where cmd_valid is still being loaded.
  assign accept_s       = (state_r == ST_IDLE) & udr_evt_s;
  assign pending_s      = cmd_valid_r & ~cmd_ready;
  assign done_s         = ~load_r & ~(|pending_s);
  assign sel_bad_s      = load_r & ~sel_ok_s;
  assign tmo_inc_s      = tmo_r + TMOW'(1);
  assign tmo_hit_s      = (tmo_inc_s == TMOW'(TIMEOUT_CYC));
  assign overrun_fire_s = udr_evt_s & (state_r != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (udr_evt_s) state_nxt = ST_DISPATCH;
        else           state_nxt = ST_IDLE;
      end
      ST_DISPATCH: begin
        if (sel_bad_s || done_s || tmo_hit_s) state_nxt = ST_IDLE;
        else                                  state_nxt = ST_DISPATCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; a completed handshake outranks a coincident timeout.
  always_comb begin
    cmd_valid_nxt = '0;
    complete_s    = 1'b0;
    tmo_fire_s    = 1'b0;
    sel_fire_s    = 1'b0;
    case (state_r)
      ST_IDLE: cmd_valid_nxt = '0;
      ST_DISPATCH: begin
        if (sel_bad_s)      sel_fire_s    = 1'b1;
        else if (done_s)    complete_s    = 1'b1;
        else if (tmo_hit_s) tmo_fire_s    = 1'b1;
        else if (load_r)    cmd_valid_nxt = tgt_s;
        else                cmd_valid_nxt = pending_s;
      end
      default: cmd_valid_nxt = '0;
    endcase
  end

  // Dispatch datapath: valids, timeout counter, completion count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid_r <= '0;
      load_r      <= 1'b0;
      busy_r      <= 1'b0;
      tmo_r       <= '0;
      cmd_count_r <= 16'd0;
    end else begin
      cmd_valid_r <= cmd_valid_nxt;
      load_r      <= accept_s;
      busy_r      <= (state_nxt != ST_IDLE);
      tmo_r       <= ((state_r == ST_DISPATCH) && (state_nxt == ST_DISPATCH)) ? tmo_inc_s : '0;
      if (complete_s) cmd_count_r <= cmd_count_r + 16'd1;
      else            cmd_count_r <= cmd_count_r;
    end
  end

  // Command and IR capture; both hold between loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      jdo_r  <= '0;
      sel_r  <= '0;
      ir_q_r <= '0;
    end else begin
      if (accept_s) begin
        jdo_r <= jtag_sr;
        sel_r <= jtag_sel;
      end else begin
        jdo_r <= jdo_r;
        sel_r <= sel_r;
      end
      if (uir_evt_s) ir_q_r <= jtag_ir;
      else           ir_q_r <= ir_q_r;
    end
  end

  // Sticky error flags; a new set wins over err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overrun_r <= 1'b0;
      err_timeout_r <= 1'b0;
      err_sel_r     <= 1'b0;
    end else begin
      err_overrun_r <= overrun_fire_s | (err_overrun_r & ~err_clr);
      err_timeout_r <= tmo_fire_s     | (err_timeout_r & ~err_clr);
      err_sel_r     <= sel_fire_s     | (err_sel_r     & ~err_clr);
    end
  end

  assign jdo         = jdo_r;
  assign ir_q        = ir_q_r;
  assign cmd_valid   = cmd_valid_r;
  assign busy        = busy_r;
  assign err_overrun = err_overrun_r;
  assign err_timeout = err_timeout_r;
  assign err_sel     = err_sel_r;
  assign cmd_count   = cmd_count_r;

endmodule

// File: tb/tb_debug_cmd_dispatch.sv
// Directed bench: a 4-core broadcast-capable instance and a 3-core instance without broadcast.
module tb_debug_cmd_dispatch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        udr, uir, err_clr;
  logic [1:0]  ir;
  logic [37:0] sr;
  logic [2:0]  sel;
  logic [3:0]  ready;
  logic [37:0] a_jdo;
  logic [1:0]  a_ir_q;
  logic [3:0]  a_valid;
  logic        a_busy, a_eo, a_et, a_es;
  logic [15:0] a_count;

  logic        b_udr, b_err_clr;
  logic [1:0]  b_sel;
  logic [2:0]  b_ready;
  logic [37:0] b_jdo;
  logic [1:0]  b_ir_q;
  logic [2:0]  b_valid;
  logic        b_busy, b_eo, b_et, b_es;
  logic [15:0] b_count;

  int checks = 0;
  int failures = 0;

  debug_cmd_dispatch #(.NUM_CORES(4), .TIMEOUT_CYC(15), .BCAST_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .jtag_udr_tgl(udr), .jtag_uir_tgl(uir), .jtag_ir(ir),
    .jtag_sr(sr), .jtag_sel(sel), .cmd_ready(ready), .err_clr(err_clr),
    .jdo(a_jdo), .ir_q(a_ir_q), .cmd_valid(a_valid), .busy(a_busy),
    .err_overrun(a_eo), .err_timeout(a_et), .err_sel(a_es), .cmd_count(a_count)
  );

  debug_cmd_dispatch #(.NUM_CORES(3), .TIMEOUT_CYC(15), .BCAST_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .jtag_udr_tgl(b_udr), .jtag_uir_tgl(uir), .jtag_ir(ir),
    .jtag_sr(sr), .jtag_sel(b_sel), .cmd_ready(b_ready), .err_clr(b_err_clr),
    .jdo(b_jdo), .ir_q(b_ir_q), .cmd_valid(b_valid), .busy(b_busy),
    .err_overrun(b_eo), .err_timeout(b_et), .err_sel(b_es), .cmd_count(b_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bounded wait for dut_a to raise any cmd_valid; returns the cycles taken.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((a_valid == 4'b0000) && (n < 20));
  endtask

  task automatic test_reset();
    reset = 1'b1; udr = 1'b1; uir = 1'b1; ir = 2'b11; sr = 38'h3F_FFFF_FFFF;
    sel = 3'd1; ready = 4'b0000; err_clr = 1'b0;
    b_udr = 1'b1; b_sel = 2'd0; b_ready = 3'b000; b_err_clr = 1'b0;
    tick_n(6);
    checks++; if (a_valid !== 4'b0000) begin failures++; $display("FAIL rst_valid got=%b want=0000", a_valid); end
    checks++; if (a_count !== 16'd0) begin failures++; $display("FAIL rst_count got=%0d want=0", a_count); end
    checks++; if ({a_eo, a_et, a_es} !== 3'b000) begin failures++; $display("FAIL rst_errs got=%b want=000", {a_eo, a_et, a_es}); end
    reset = 1'b0;
    tick_n(8);
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rst_release_busy got=%b want=0", a_busy); end
    checks++; if (a_ir_q !== 2'b00) begin failures++; $display("FAIL rst_release_ir got=%b want=00", a_ir_q); end
    checks++; if (a_jdo !== 38'h0) begin failures++; $display("FAIL rst_release_jdo got=%h want=0", a_jdo); end
  endtask

  task automatic test_ir();
    ir = 2'b10;
    uir = ~uir;
    tick_n(2);
    checks++; if (a_ir_q !== 2'b00) begin failures++; $display("FAIL ir_early got=%b want=00", a_ir_q); end
    tick();
    checks++; if (a_ir_q !== 2'b10) begin failures++; $display("FAIL ir_load got=%b want=10", a_ir_q); end
    ir = 2'b01;
    tick_n(3);
    checks++; if (a_ir_q !== 2'b10) begin failures++; $display("FAIL ir_hold got=%b want=10", a_ir_q); end
  endtask

  task automatic test_single();
    int n;
    sel = 3'd2; sr = 38'h2A_0000_0001; ready = 4'b0100;
    udr = ~udr;
    wait_valid(n);
    checks++; if (n != 4) begin failures++; $display("FAIL single_latency got=%0d want=4", n); end
    checks++; if (a_valid !== 4'b0100) begin failures++; $display("FAIL single_valid got=%b want=0100", a_valid); end
    checks++; if (a_jdo !== 38'h2A_0000_0001) begin failures++; $display("FAIL single_jdo got=%h want=2a00000001", a_jdo); end
    tick();
    checks++; if (a_valid !== 4'b0000) begin failures++; $display("FAIL single_drop got=%b want=0000", a_valid); end
    checks++; if (a_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d want=1", a_count); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b want=0", a_busy); end
    ready = 4'b0000;
  endtask

  task automatic test_broadcast();
    int n;
    logic [3:0] exp_v;
    sel = 3'd4; ready = 4'b0000;
    udr = ~udr;
    wait_valid(n);
    checks++; if (a_valid !== 4'b1111) begin failures++; $display("FAIL bcast_valid got=%b want=1111", a_valid); end
    exp_v = 4'b1111;
    for (int i = 1; i <= 8; i++) begin
      if (i % 2 == 1) begin
        ready = 4'b0001 << ((i - 1) / 2);
        exp_v = exp_v & ~(4'b0001 << ((i - 1) / 2));
      end else begin
        ready = 4'b0000;
      end
      tick();
      checks++; if (a_valid !== exp_v) begin failures++; $display("FAIL bcast_step%0d got=%b want=%b", i, a_valid, exp_v); end
      checks++; if (a_busy !== (exp_v != 4'b0000)) begin failures++; $display("FAIL bcast_busy%0d got=%b want=%b", i, a_busy, exp_v != 4'b0000); end
    end
    ready = 4'b0000;
    checks++; if (a_count !== 16'd2) begin failures++; $display("FAIL bcast_count got=%0d want=2", a_count); end
    checks++; if ({a_eo, a_et, a_es} !== 3'b000) begin failures++; $display("FAIL bcast_errs got=%b want=000", {a_eo, a_et, a_es}); end
  endtask

  task automatic test_timeout();
    int bc, vc;
    bc = 0; vc = 0;
    sel = 3'd1; ready = 4'b0000;
    udr = ~udr;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (a_busy === 1'b1) bc++;
      if (a_valid === 4'b0010) vc++;
    end
    checks++; if (bc != 15) begin failures++; $display("FAIL tmo_busy_cycles got=%0d want=15", bc); end
    checks++; if (vc != 14) begin failures++; $display("FAIL tmo_valid_cycles got=%0d want=14", vc); end
    checks++; if (a_et !== 1'b1) begin failures++; $display("FAIL tmo_flag got=%b want=1", a_et); end
    checks++; if (a_count !== 16'd2) begin failures++; $display("FAIL tmo_count got=%0d want=2", a_count); end
    checks++; if (a_valid !== 4'b0000) begin failures++; $display("FAIL tmo_valid got=%b want=0000", a_valid); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (a_et !== 1'b0) begin failures++; $display("FAIL tmo_clr got=%b want=0", a_et); end
  endtask

  task automatic test_overrun();
    int n;
    sel = 3'd0; sr = 38'h15_5555_AAAA; ready = 4'b0000;
    udr = ~udr;
    wait_valid(n);
    checks++; if (a_valid !== 4'b0001) begin failures++; $display("FAIL ovr_valid got=%b want=0001", a_valid); end
    sr = 38'h0A_1234_5678;
    udr = ~udr;
    tick_n(4);
    checks++; if (a_eo !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b want=1", a_eo); end
    checks++; if (a_jdo !== 38'h15_5555_AAAA) begin failures++; $display("FAIL ovr_jdo got=%h want=155555aaaa", a_jdo); end
    checks++; if (a_valid !== 4'b0001) begin failures++; $display("FAIL ovr_still_valid got=%b want=0001", a_valid); end
    ready = 4'b0001;
    tick();
    ready = 4'b0000;
    checks++; if (a_count !== 16'd3) begin failures++; $display("FAIL ovr_count got=%0d want=3", a_count); end
    tick_n(4);
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL ovr_dropped got=%b want=0", a_busy); end
    // Second toggle lands in the same cycle as the final handshake.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (a_eo !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b want=0", a_eo); end
    sel = 3'd3; sr = 38'h00_0000_00FF;
    udr = ~udr;
    wait_valid(n);
    checks++; if (a_valid !== 4'b1000) begin failures++; $display("FAIL coin_valid got=%b want=1000", a_valid); end
    udr = ~udr;
    tick_n(2);
    ready = 4'b1000;
    tick();
    ready = 4'b0000;
    checks++; if (a_count !== 16'd4) begin failures++; $display("FAIL coin_count got=%0d want=4", a_count); end
    checks++; if (a_eo !== 1'b1) begin failures++; $display("FAIL coin_overrun got=%b want=1", a_eo); end
    tick_n(4);
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL coin_busy got=%b want=0", a_busy); end
    checks++; if (a_jdo !== 38'h00_0000_00FF) begin failures++; $display("FAIL coin_jdo got=%h want=ff", a_jdo); end
  endtask

  task automatic test_bad_sel();
    logic [2:0] or_v;
    or_v = 3'b000;
    b_sel = 2'd3; sr = 38'h11_2233_4455;
    b_udr = ~b_udr;
    for (int i = 0; i < 8; i++) begin
      tick();
      or_v = or_v | b_valid;
    end
    checks++; if (b_es !== 1'b1) begin failures++; $display("FAIL badsel_flag got=%b want=1", b_es); end
    checks++; if (or_v !== 3'b000) begin failures++; $display("FAIL badsel_valid got=%b want=000", or_v); end
    checks++; if ({b_busy, b_count} !== 17'd0) begin failures++; $display("FAIL badsel_busy_count got=%h want=0", {b_busy, b_count}); end
    checks++; if (b_jdo !== 38'h11_2233_4455) begin failures++; $display("FAIL badsel_jdo got=%h want=1122334455", b_jdo); end
    checks++; if (b_ir_q !== 2'b10) begin failures++; $display("FAIL badsel_ir got=%b want=10", b_ir_q); end
    b_err_clr = 1'b1;
    tick();
    b_err_clr = 1'b0;
    checks++; if ({b_eo, b_et, b_es} !== 3'b000) begin failures++; $display("FAIL badsel_clr got=%b want=000", {b_eo, b_et, b_es}); end
  endtask

  task automatic test_reset_mid();
    int n;
    sel = 3'd1; ready = 4'b0000;
    udr = ~udr;
    wait_valid(n);
    checks++; if (a_valid !== 4'b0010) begin failures++; $display("FAIL rmid_valid got=%b want=0010", a_valid); end
    reset = 1'b1;
    tick();
    checks++; if (a_valid !== 4'b0000) begin failures++; $display("FAIL rmid_drop got=%b want=0000", a_valid); end
    checks++; if ({a_busy, a_count} !== 17'd0) begin failures++; $display("FAIL rmid_busy_count got=%h want=0", {a_busy, a_count}); end
    reset = 1'b0;
    tick_n(6);
    checks++; if ({a_busy, a_valid} !== 5'd0) begin failures++; $display("FAIL rmid_release got=%b want=00000", {a_busy, a_valid}); end
  endtask

  initial begin
    test_reset();
    test_ir();
    test_single();
    test_broadcast();
    test_timeout();
    test_overrun();
    test_bad_sel();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
